// File: rtl/mul_acc_pkg.sv
// ---------------------------------------------------------------------------
// mul_acc_pkg
// Shared types and helpers for the frame accumulator that sits behind the
// combinational multiplier.
//   mul_acc_state_t : FSM encoding (IDLE / ACC / HOLD)
//   sat_res_t       : result of a saturating add (sum + carry-out flag)
//   sat_add()       : unsigned add of two values narrower than MAX_W, with
//                     saturation to all ones at a caller-chosen width
// ---------------------------------------------------------------------------
package mul_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } mul_acc_state_t;

    // Widest accumulator the helper can handle; callers use widths below it.
    localparam int MAX_W = 128;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] sum;
    } sat_res_t;

    // Both operands must already fit in 'width' bits. The carry out of bit
    // width-1 is then simply bit 'width' of the full-precision sum.
    function automatic sat_res_t sat_add(
        input logic [MAX_W-1:0] acc,
        input logic [MAX_W-1:0] prod,
        input logic [7:0]       width
    );
        logic [MAX_W:0]   full;
        logic [MAX_W-1:0] mask;
        sat_res_t         res;
        full    = {1'b0, acc} + {1'b0, prod};
        mask    = {MAX_W{1'b1}} >> (8'(MAX_W) - width);
        res.ovf = full[width];
        res.sum = res.ovf ? mask : full[MAX_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/mul_accumulator_if.sv
// ---------------------------------------------------------------------------
// mul_accumulator_if
// Bundles the product input channel, the result output channel and the
// frame controls of mul_accumulator.
//   clear      : synchronous abort/flush (driven by master)
//   frame_len  : beats per frame, sampled on the first beat
//   in_*       : product channel (valid/ready)
//   out_*      : result channel (valid/ready), acc/count/ovf payload
//   dbg_state  : current FSM state, for observation only
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both 1; the source holds valid and payload
// stable until that edge, and ready may depend combinationally on the
// sink's state but never on valid.
// ---------------------------------------------------------------------------
interface mul_accumulator_if
    import mul_acc_pkg::*;
#(
    parameter int N     = 32,
    parameter int GUARD = 8,
    parameter int CNT_W = 16
);
    localparam int ACC_W = 2 * N + GUARD;

    logic                 clear;
    logic [CNT_W-1:0]     frame_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*N-1:0]       in_prod;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_acc;
    logic [CNT_W-1:0]     out_count;
    logic                 out_ovf;
    mul_acc_state_t       dbg_state;

    modport master (
        output clear, frame_len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf, dbg_state
    );

    modport slave (
        input  clear, frame_len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf, dbg_state
    );

endinterface

// File: rtl/mul_acc_sat_adder.sv
// ---------------------------------------------------------------------------
// mul_acc_sat_adder
// Combinational ACC_W-bit unsigned add of the running sum and a zero-extended
// product. On carry out the sum is replaced by all ones.
//   i_acc   : running accumulator value
//   i_prod  : new product (PROD_W <= ACC_W)
//   o_sum   : saturated sum
//   o_carry : the add overflowed ACC_W bits
// ---------------------------------------------------------------------------
module mul_acc_sat_adder
    import mul_acc_pkg::*;
#(
    parameter int ACC_W  = 72,
    parameter int PROD_W = 64
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    sat_res_t                 w_res;
    logic [MAX_W-ACC_W-1:0]   w_unused_hi;

    assign w_res       = sat_add(MAX_W'(i_acc), MAX_W'(i_prod), 8'(ACC_W));
    assign o_sum       = w_res.sum[ACC_W-1:0];
    assign o_carry     = w_res.ovf;
    // Bits above ACC_W are always zero after saturation masking.
    assign w_unused_hi = w_res.sum[MAX_W-1:ACC_W];

endmodule

// File: rtl/mul_accumulator.sv
// ---------------------------------------------------------------------------
// mul_accumulator
// Sums runs of frame_len unsigned products into a guarded accumulator and
// presents sum, beat count and sticky overflow on a registered result port.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mul_accumulator_if (clear, frame_len, product
//           channel, result channel, debug state)
// FSM: IDLE (waiting for first beat) -> ACC (collecting) -> HOLD (result
// valid). A taken result with a simultaneous beat starts the next frame
// directly from HOLD, so back-to-back frames have no bubble.
// ---------------------------------------------------------------------------
module mul_accumulator
    import mul_acc_pkg::*;
#(
    parameter int N     = 32,
    parameter int GUARD = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_accumulator_if.slave  bus
);

    localparam int ACC_W  = 2 * N + GUARD;
    localparam int PROD_W = 2 * N;

    mul_acc_state_t   r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_beat;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic [CNT_W-1:0] w_len_eff;
    logic [CNT_W-1:0] w_cnt_inc;

    // A zero frame length would never terminate; treat it as one beat.
    assign w_len_eff  = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // In HOLD a new beat may only enter when the pending result leaves in
    // the same cycle; clear blocks all input so nothing is half-consumed.
    assign w_in_ready = ~bus.clear & ((r_state != HOLD) | bus.out_ready);
    assign w_beat     = bus.in_valid & w_in_ready;

    mul_acc_sat_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_adder (
        .i_acc   (r_acc),
        .i_prod  (bus.in_prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len   <= CNT_W'(1);
            r_ovf   <= 1'b0;
        end else if (bus.clear) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_beat) begin
                        // First beat of a frame (from HOLD this implies the
                        // previous result was taken on this same edge).
                        r_acc   <= ACC_W'(bus.in_prod);
                        r_cnt   <= CNT_W'(1);
                        r_len   <= w_len_eff;
                        r_ovf   <= 1'b0;
                        r_state <= (w_len_eff == CNT_W'(1)) ? HOLD : ACC;
                    end else if ((r_state == HOLD) && bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                ACC: begin
                    if (w_beat) begin
                        // Once saturated the sum stays all ones: adding to
                        // all ones either carries again or adds zero.
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_carry;
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            r_state <= HOLD;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_acc   = r_acc;
    assign bus.out_count = r_cnt;
    assign bus.out_ovf   = r_ovf;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mul_accumulator.sv
module tb_mul_accumulator;
    import mul_acc_pkg::*;

    localparam int N       = 32;
    localparam int GUARD   = 8;
    localparam int CNT_W   = 16;
    localparam int ACC_W   = 2 * N + GUARD;
    localparam int EW      = 1 + CNT_W + ACC_W;
    localparam logic [127:0] MAX_ACC = (128'd1 << ACC_W) - 128'd1;
    localparam logic [63:0]  ONES64  = 64'hFFFF_FFFF_FFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    mul_accumulator_if #(.N(N), .GUARD(GUARD), .CNT_W(CNT_W)) bus ();
    mul_accumulator_if #(.N(N), .GUARD(0),     .CNT_W(CNT_W)) bus_s ();

    mul_accumulator #(.N(N), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mul_accumulator #(.N(N), .GUARD(0), .CNT_W(CNT_W)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    // ---------------- out_ready control ----------------
    logic rand_en;
    logic ready_fixed;
    logic ready_rand;

    assign bus.out_ready = rand_en ? ready_rand : ready_fixed;

    always @(posedge clk) begin
        #1;
        ready_rand = ($urandom_range(0, 3) != 0);
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks;
    int failures;

    function automatic logic [EW-1:0] mk_exp(input logic [127:0] s, input int cnt);
        logic             ovf;
        logic [ACC_W-1:0] acc;
        ovf = (s > MAX_ACC);
        acc = ovf ? {ACC_W{1'b1}} : s[ACC_W-1:0];
        return {ovf, CNT_W'(cnt), acc};
    endfunction

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && bus.out_valid && bus.out_ready && !bus.clear) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_result got acc=%0h count=%0d ovf=%0b required=none",
                         bus.out_acc, bus.out_count, bus.out_ovf);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_ovf, bus.out_count, bus.out_acc} !== e) begin
                    failures++;
                    $display("FAIL sb_result got acc=%0h count=%0d ovf=%0b required acc=%0h count=%0d ovf=%0b",
                             bus.out_acc, bus.out_count, bus.out_ovf,
                             e[ACC_W-1:0], e[ACC_W+CNT_W-1:ACC_W], e[EW-1]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call from just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [63:0] p);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout got in_ready=0 required in_ready=1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_beat_s(input logic [63:0] p);
        bus_s.in_valid = 1'b1;
        bus_s.in_prod  = p;
        @(negedge clk);
        checks++;
        if (bus_s.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sat_in_ready got %0b required 1", bus_s.in_ready);
        end
        @(posedge clk);
        #1;
        bus_s.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.dbg_state != IDLE) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.dbg_state !== IDLE) begin
            failures++;
            $display("FAIL drain_%s got pending=%0d state=%0d required pending=0 state=IDLE",
                     name, exp_q.size(), bus.dbg_state);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got %0b required 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got %0b required 0", bus.out_valid);
        end
        checks++;
        if (bus.out_acc !== '0) begin
            failures++; $display("FAIL reset_out_acc got %0h required 0", bus.out_acc);
        end
        checks++;
        if (bus.out_count !== '0 || bus.out_ovf !== 1'b0) begin
            failures++; $display("FAIL reset_count_ovf got %0d/%0b required 0/0", bus.out_count, bus.out_ovf);
        end
        checks++;
        if (bus.dbg_state !== IDLE) begin
            failures++; $display("FAIL reset_state got %0d required IDLE", bus.dbg_state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        ready_fixed   = 1'b1;
        bus.frame_len = 16'd4;
        exp_q.push_back(mk_exp(128'd24, 4));
        send_beat(64'd3);
        send_beat(64'd5);
        send_beat(64'd7);
        send_beat(64'd9);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL basic_latency got out_valid=%0b required 1", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_one_cycle got out_valid=%0b required 0", bus.out_valid);
        end
        wait_drain("basic");
    endtask

    task automatic test_back_to_back();
        ready_fixed   = 1'b0;
        bus.frame_len = 16'd2;
        exp_q.push_back(mk_exp(128'd30, 2));
        exp_q.push_back(mk_exp(128'd3, 2));
        send_beat(64'd10);
        send_beat(64'd20);
        bus.in_valid = 1'b1;
        bus.in_prod  = 64'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_in_ready cycle %0d got %0b required 0", i, bus.in_ready);
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_acc !== ACC_W'(30) || bus.out_count !== 16'd2) begin
                failures++;
                $display("FAIL bp_hold cycle %0d got valid=%0b acc=%0h count=%0d required 1/1e/2",
                         i, bus.out_valid, bus.out_acc, bus.out_count);
            end
        end
        @(posedge clk);
        #1;
        ready_fixed = 1'b1;
        send_beat(64'd1);
        @(negedge clk);
        checks++;
        if (bus.dbg_state !== ACC || bus.out_count !== 16'd1) begin
            failures++;
            $display("FAIL bp_no_bubble got state=%0d count=%0d required ACC/1", bus.dbg_state, bus.out_count);
        end
        @(posedge clk);
        #1;
        send_beat(64'd2);
        wait_drain("back_to_back");
    endtask

    task automatic test_len_edges();
        logic [63:0] p;
        p = 64'hFFFF_FFFF_0000_0001;
        ready_fixed   = 1'b1;
        bus.frame_len = 16'd0;
        exp_q.push_back(mk_exp({64'd0, p}, 1));
        send_beat(p);
        bus.frame_len = 16'd1;
        exp_q.push_back(mk_exp({64'd0, p}, 1));
        send_beat(p);
        @(negedge clk);
        checks++;
        if (bus.dbg_state !== HOLD) begin
            failures++; $display("FAIL len1_state got %0d required HOLD", bus.dbg_state);
        end
        @(posedge clk);
        #1;
        // frame_len altered mid-frame must not shorten the frame
        bus.frame_len = 16'd3;
        exp_q.push_back(mk_exp(128'd6, 3));
        send_beat(64'd1);
        bus.frame_len = 16'd1;
        send_beat(64'd2);
        send_beat(64'd3);
        wait_drain("len_edges");
    endtask

    task automatic test_saturation();
        bus_s.frame_len = 16'd3;
        send_beat_s(ONES64);
        send_beat_s(64'd1);
        send_beat_s(64'd5);
        bus_s.frame_len = 16'd1;
        @(negedge clk);
        checks++;
        if (bus_s.out_valid !== 1'b1 || bus_s.out_acc !== ONES64) begin
            failures++;
            $display("FAIL sat_acc got valid=%0b acc=%0h required 1/ffffffffffffffff", bus_s.out_valid, bus_s.out_acc);
        end
        checks++;
        if (bus_s.out_ovf !== 1'b1 || bus_s.out_count !== 16'd3) begin
            failures++;
            $display("FAIL sat_ovf got ovf=%0b count=%0d required 1/3", bus_s.out_ovf, bus_s.out_count);
        end
        @(posedge clk);
        #1;
        send_beat_s(64'd7);
        @(negedge clk);
        checks++;
        if (bus_s.out_ovf !== 1'b0 || bus_s.out_acc !== 64'd7 || bus_s.out_count !== 16'd1) begin
            failures++;
            $display("FAIL sat_next_frame got ovf=%0b acc=%0h count=%0d required 0/7/1",
                     bus_s.out_ovf, bus_s.out_acc, bus_s.out_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        ready_fixed   = 1'b1;
        bus.frame_len = 16'd8;
        send_beat(64'd1);
        send_beat(64'd1);
        send_beat(64'd1);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_prod  = 64'd1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL clear_in_ready got %0b required 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dbg_state !== IDLE || bus.out_acc !== '0 || bus.out_count !== '0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_state got state=%0d acc=%0h count=%0d valid=%0b required IDLE/0/0/0",
                     bus.dbg_state, bus.out_acc, bus.out_count, bus.out_valid);
        end
        @(posedge clk);
        #1;
        bus.frame_len = 16'd2;
        exp_q.push_back(mk_exp(128'd8, 2));
        send_beat(64'd4);
        send_beat(64'd4);
        wait_drain("clear");
    endtask

    task automatic test_random();
        logic [63:0]  prods[16];
        logic [127:0] s;
        logic [31:0]  a;
        logic [31:0]  b;
        int           len;
        rand_en = 1'b1;
        for (int f = 0; f < 512; f++) begin
            len = $urandom_range(1, 16);
            s   = '0;
            for (int k = 0; k < len; k++) begin
                a        = $urandom;
                b        = $urandom;
                prods[k] = 64'(a) * 64'(b);
                s        = s + 128'(prods[k]);
            end
            exp_q.push_back(mk_exp(s, len));
            bus.frame_len = CNT_W'(len);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send_beat(prods[k]);
                bus.frame_len = CNT_W'($urandom);
            end
        end
        rand_en     = 1'b0;
        ready_fixed = 1'b1;
        wait_drain("random");
    endtask

    task automatic test_async_reset();
        ready_fixed   = 1'b1;
        bus.frame_len = 16'd5;
        send_beat(64'd3);
        send_beat(64'd4);
        send_beat(64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_acc !== '0 || bus.out_count !== '0 || bus.out_valid !== 1'b0 || bus.out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_frame got acc=%0h count=%0d valid=%0b ovf=%0b required 0/0/0/0",
                     bus.out_acc, bus.out_count, bus.out_valid, bus.out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.dbg_state !== IDLE) begin
            failures++; $display("FAIL rst_resume got in_ready=%0b state=%0d required 1/IDLE", bus.in_ready, bus.dbg_state);
        end
        bus.frame_len = 16'd2;
        exp_q.push_back(mk_exp(128'd11, 2));
        send_beat(64'd5);
        send_beat(64'd6);
        wait_drain("rst_mid_frame");

        ready_fixed   = 1'b0;
        bus.frame_len = 16'd1;
        send_beat(64'd9);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== ACC_W'(9)) begin
            failures++; $display("FAIL rst_pre_hold got valid=%0b acc=%0h required 1/9", bus.out_valid, bus.out_acc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_acc !== '0 || bus.out_count !== '0 || bus.out_valid !== 1'b0 || bus.out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_hold got acc=%0h count=%0d valid=%0b ovf=%0b required 0/0/0/0",
                     bus.out_acc, bus.out_count, bus.out_valid, bus.out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.dbg_state !== IDLE) begin
            failures++; $display("FAIL rst_hold_resume got in_ready=%0b state=%0d required 1/IDLE", bus.in_ready, bus.dbg_state);
        end
        ready_fixed   = 1'b1;
        bus.frame_len = 16'd2;
        exp_q.push_back(mk_exp(128'd5, 2));
        send_beat(64'd2);
        send_beat(64'd3);
        wait_drain("rst_in_hold");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks         = 0;
        failures       = 0;
        rand_en        = 1'b0;
        ready_fixed    = 1'b1;
        ready_rand     = 1'b1;
        rst_n          = 1'b0;
        bus.clear      = 1'b0;
        bus.frame_len  = 16'd1;
        bus.in_valid   = 1'b0;
        bus.in_prod    = '0;
        bus_s.clear     = 1'b0;
        bus_s.frame_len = 16'd1;
        bus_s.in_valid  = 1'b0;
        bus_s.in_prod   = '0;
        bus_s.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        test_reset();
        test_basic();
        test_back_to_back();
        test_len_edges();
        test_saturation();
        test_clear();
        test_random();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_accumulator.md
# mul_accumulator

Frame-based accumulator that sits directly downstream of `multipler_comb`. It takes the 2N-bit unsigned products over a valid/ready handshake and sums a run of `frame_len` products into a wide accumulator with guard bits. It presents the sum, the beat count and a sticky overflow flag on a registered valid/ready output. It is the first sequential stage after the combinational multiplier in the MAC datapath.

## Interface
- `N`, 32, operand width of the upstream multiplier; the product is 2N bits.
- `GUARD`, 8, extra accumulator MSBs; `ACC_W = 2*N + GUARD`.
- `CNT_W`, 16, width of the frame length and beat counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort and flush, highest priority.
- `frame_len`  in  CNT_W  beats per frame; sampled only on the first beat of a frame.
- `in_valid`  in  1  a product is present.
- `in_ready`  out  1  the block accepts a product this cycle.
- `in_prod`  in  2N  unsigned product (`m` of the multiplier).
- `out_valid`  out  1  a result is held.
- `out_ready`  in  1  downstream takes the result.
- `out_acc`  out  ACC_W  frame sum, or saturated value.
- `out_count`  out  CNT_W  number of beats summed.
- `out_ovf`  out  1  the frame saturated.

## Operation
- Beat accepted = `in_valid & in_ready`. Result taken = `out_valid & out_ready`.
- FSM states: IDLE, ACC, HOLD.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On a beat: acc←zero-extended `in_prod`, cnt←1, len←`frame_len` (a value of 0 is treated as 1), ovf←0.
  - Next state is HOLD if len==1, otherwise ACC.
- ACC:
  - `in_ready`=1.
  - On a beat: acc←acc+`in_prod`, cnt←cnt+1.
  - Go to HOLD when the new cnt equals len. With no beat, stay in ACC and keep all state.
- HOLD:
  - `out_valid`=1; `out_acc`/`out_count`/`out_ovf` are stable until the result is taken.
  - `in_ready`=`out_ready` (combinational pass-through).
  - Result taken without a beat → IDLE.
  - Result taken with a simultaneous beat → start a new frame exactly as the IDLE first beat, with no bubble.
  - Result not taken → stay in HOLD. `in_valid` is ignored because `in_ready`=0.
- Arithmetic: unsigned, ACC_W-bit sum with carry detect.
  - On carry out: acc←all ones, ovf←1.
  - While ovf=1, acc stays all ones and further beats still increment cnt.
- `clear`=1:
  - Next state IDLE; acc, cnt and ovf←0; any pending result is dropped.
  - `in_ready` is forced to 0 in that cycle, so no beat is consumed.
- Reset (asynchronous, any state, including mid-frame or with a result pending):
  - State IDLE; `out_valid`=0, `out_acc`=0, `out_count`=0, `out_ovf`=0.
  - `in_ready` is 1 once reset is released.

## Timing
- `in_ready` is combinational from state, `out_ready` and `clear`. All other outputs are registered.
- Latency: `out_valid` rises on the clock edge that accepts the last beat, so the result is visible the cycle after that beat.
- Throughput: one beat per cycle. Back-to-back frames lose no cycle provided `out_ready`=1 in HOLD.
- A frame of L beats with continuous `in_valid` occupies L cycles plus one HOLD cycle. That HOLD cycle overlaps the next frame's first beat.
- `frame_len` changes during a frame have no effect until the next first beat.

## Structure
- Package `mul_acc_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACC, HOLD} mul_acc_state_t`.
  - Helper function `sat_add(acc, prod)` returning the sum and an overflow bit.
- One natural sub-module: `mul_acc_sat_adder`, a combinational ACC_W-bit add with carry-to-saturate. The FSM, counter and output registers live in `mul_accumulator`.
- The integration top places `multipler_comb` (N=32) ahead of this block. Its `m` feeds `in_prod`.

## Test plan
- Basic frame: `frame_len`=4, products 3, 5, 7, 9 on consecutive cycles, `out_ready`=1 → `out_acc`=24, `out_count`=4, `out_ovf`=0; `out_valid` for one cycle, the cycle after the 4th beat.
- Backpressure and back-to-back:
  - `frame_len`=2, products 10, 20, then 1, 2.
  - `out_ready`=0 for 3 cycles → result 30 held stable, `in_ready`=0, beat "1" stalls.
  - `out_ready`=1 → 30 taken while "1" is accepted in the same cycle; the next result is 3.
- Length edge cases: `frame_len`=0 and `frame_len`=1 with product 0xFFFF_FFFF_0000_0001 → single-beat result equal to the product, `out_count`=1.
- Saturation: N=32, GUARD=0, `frame_len`=3, products 2^64−1, 1, 5 → `out_acc`=2^64−1, `out_ovf`=1, `out_count`=3. The next frame reports `out_ovf`=0.
- Clear mid-frame: `frame_len`=8; after 3 beats (1, 1, 1) assert `clear` for 1 cycle with `in_valid`=1 → no beat consumed, state IDLE. A new frame of 2 beats (4, 4) gives 8.
- Random sweep and reset:
  - 512 frames: random `frame_len` 1..16, random `a`/`b` multiplied by `multipler_comb` (N=32), random valid/ready stalls. Check against a reference sum.
  - Assert `rst_n`=0 asynchronously in mid-frame and in HOLD → all outputs 0 immediately; resumes cleanly.
